// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with byte FIFO,
// programmable bit period and a level "drained" interrupt.
module uart_tx_port #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DIV_RESET = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:2]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t         state, state_nxt;
   logic [7:0]     mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr, count;
   logic           full, empty, accept;
   logic           overflow, irq_en;
   logic [DW-1:0]  divisor, baud_cnt;
   logic [7:0]     shift_q;
   logic [2:0]     idx_q;
   logic           bit_end;
   logic           wr_data, wr_status, wr_ctrl, wr_div;
   logic           unused_din;

   // control outputs of the FSM (combinational)
   logic           pop_c, load_baud_c, tx_c;
   logic [7:0]     shift_nxt_c;
   logic [2:0]     idx_nxt_c;

   assign wr_data    = WE && (Addr == 2'd0);
   assign wr_status  = WE && (Addr == 2'd1);
   assign wr_ctrl    = WE && (Addr == 2'd2);
   assign wr_div     = WE && (Addr == 2'd3);
   assign unused_din = ^Din[31:16];

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a same-cycle pop frees the slot, so a push while full still lands
   assign accept  = wr_data && (!full || pop_c);
   assign bit_end = (baud_cnt == '0);

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // FIFO storage (no reset needed; guarded by pointers)
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[AW-1:0]] <= Din[7:0];
   end

   // software-visible configuration and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         irq_en   <= 1'b0;
         divisor  <= DW'(DIV_RESET);
      end else begin
         if (wr_data && full && !pop_c) overflow <= 1'b1;
         else if (wr_status)            overflow <= 1'b0;
         if (wr_ctrl) irq_en <= Din[0];
         if (wr_div)  divisor <= (Din[15:0] < 16'd2) ? 16'd2 : Din[15:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!empty) state_nxt = S_START;
         S_START: if (bit_end) state_nxt = S_DATA;
         S_DATA:  if (bit_end && (idx_q == 3'd7)) state_nxt = S_STOP;
         S_STOP:  if (bit_end) state_nxt = empty ? S_IDLE : S_START;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: pop, bit-period reload, shift/index updates, next tx level
   always_comb begin
      pop_c       = 1'b0;
      load_baud_c = 1'b0;
      shift_nxt_c = shift_q;
      idx_nxt_c   = idx_q;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop_c       = 1'b1;
               load_baud_c = 1'b1;
               shift_nxt_c = mem[rd_ptr[AW-1:0]];
            end
         end
         S_START: begin
            if (bit_end) begin
               load_baud_c = 1'b1;
               idx_nxt_c   = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               load_baud_c = 1'b1;
               shift_nxt_c = {1'b0, shift_q[7:1]};
               idx_nxt_c   = idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               load_baud_c = 1'b1;
               if (!empty) begin
                  pop_c       = 1'b1;
                  shift_nxt_c = mem[rd_ptr[AW-1:0]];
               end
            end
         end
         default: ;
      endcase
      case (state_nxt)
         S_START: tx_c = 1'b0;
         S_DATA:  tx_c = shift_nxt_c[0];
         default: tx_c = 1'b1;
      endcase
   end

   // baud counter, shifter, registered tx and interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         tx       <= 1'b1;
         IRQ      <= 1'b0;
      end else begin
         if (load_baud_c)   baud_cnt <= divisor - DW'(1);
         else if (!bit_end) baud_cnt <= baud_cnt - DW'(1);
         shift_q <= shift_nxt_c;
         idx_q   <= idx_nxt_c;
         tx      <= tx_c;
         IRQ     <= irq_en && empty && (state == S_IDLE);
      end
   end

   // register read mux (no side effects)
   always_comb begin
      Dout = '0;
      case (Addr)
         2'd1:    Dout = {23'd0, 5'(count), overflow, empty, full, (state != S_IDLE)};
         2'd2:    Dout = {31'd0, irq_en};
         2'd3:    Dout = {16'd0, divisor};
         default: Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized self-checking bench; expected serial
// waveform is derived from the frame format (start, 8 data LSB first, stop).
module tb_uart_tx_port;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned DIV_RESET = 434;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  Addr = 2'd0;
   logic        WE = 1'b0;
   logic [31:0] Din = 32'd0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        tx;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  wr_bytes [16];
   int          n_wr = 0;
   bit          irq_en_m = 1'b0;

   uart_tx_port #(.DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      WE = 1'b1; Addr = a; Din = d;
      @(negedge clk);
      WE = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] e);
      @(negedge clk);
      WE = 1'b0; Addr = a;
      #1;
      check(tag, Dout, e);
   endtask

   // expected tx level c cycles after the first start bit begins
   function automatic logic exp_tx(input int c, input int div);
      int fr, bi;
      fr = c / (10 * div);
      bi = (c % (10 * div)) / div;
      if (bi == 0) return 1'b0;
      if (bi == 9) return 1'b1;
      return wr_bytes[fr][bi-1];
   endfunction

   // write n_wr bytes back-to-back and check tx/irq/busy every cycle
   task automatic run_stream(input int div, input bit ovf_probe);
      int   n_acc, len;
      logic e_tx, e_irq, e_busy;
      n_acc = (n_wr > int'(DEPTH) + 1) ? int'(DEPTH) + 1 : n_wr;
      len   = 10 * div * n_acc;
      for (int t = 0; t <= len + 4; t++) begin
         @(negedge clk);
         e_tx  = (t >= 2 && t - 2 < len) ? exp_tx(t - 2, div) : 1'b1;
         check("tx", 32'(tx), 32'(e_tx));
         e_irq = irq_en_m && (t < 2 || t >= len + 3);
         check("irq", 32'(IRQ), 32'(e_irq));
         if (t < n_wr) begin
            WE = 1'b1; Addr = 2'd0; Din = {24'($urandom), wr_bytes[t]};
         end else if (ovf_probe && t == n_wr + 1) begin
            WE = 1'b1; Addr = 2'd1; Din = $urandom;
         end else begin
            WE = 1'b0; Addr = 2'd1;
         end
         #1;
         if (!WE) begin
            e_busy = (t >= 2 && t <= len + 1);
            check("busy", 32'(Dout[0]), 32'(e_busy));
         end
         if (ovf_probe && t == n_wr)
            check("status_full", Dout,
                  32'((DEPTH << 4) | ((n_wr > int'(DEPTH) + 1) ? 8 : 0) | 3));
         if (ovf_probe && t == n_wr + 2)
            check("status_ovf_clr", Dout, 32'((DEPTH << 4) | 3));
         if (t == len + 4)
            check("status_end", Dout, 32'h4);
      end
      WE = 1'b0;
   endtask

   initial begin
      int div;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_irq", 32'(IRQ), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_check("rst_status", 2'd1, 32'h4);
      rd_check("rst_div", 2'd3, 32'(DIV_RESET));
      rd_check("rst_ctrl", 2'd2, 32'd0);
      rd_check("data_read", 2'd0, 32'd0);

      // single byte 0xA5 at divisor 4
      wr(2'd3, 32'd4);
      rd_check("div4", 2'd3, 32'd4);
      n_wr = 1; wr_bytes[0] = 8'hA5;
      run_stream(4, 1'b0);

      // random single bytes, random divisors
      repeat (4) begin
         div = int'($urandom_range(2, 6));
         wr(2'd3, 32'(div));
         n_wr = 1; wr_bytes[0] = 8'($urandom);
         run_stream(div, 1'b0);
      end

      // random short bursts
      repeat (3) begin
         div = int'($urandom_range(2, 5));
         wr(2'd3, 32'(div));
         n_wr = int'($urandom_range(1, 4));
         for (int i = 0; i < n_wr; i++) wr_bytes[i] = 8'($urandom);
         run_stream(div, 1'b0);
      end

      // back-to-back 0x00, 0xFF at divisor 2
      wr(2'd3, 32'd2);
      n_wr = 2; wr_bytes[0] = 8'h00; wr_bytes[1] = 8'hFF;
      run_stream(2, 1'b0);

      // overflow: 10 writes, 9 accepted
      wr(2'd3, 32'd100);
      n_wr = 10;
      for (int i = 0; i < n_wr; i++) wr_bytes[i] = 8'($urandom);
      run_stream(100, 1'b1);

      // interrupt enable with empty FIFO, then a frame
      wr(2'd2, 32'h1);
      check("irq_delay", 32'(IRQ), 32'd0);
      @(negedge clk);
      check("irq_set", 32'(IRQ), 32'd1);
      irq_en_m = 1'b1;
      rd_check("ctrl_en", 2'd2, 32'd1);
      wr(2'd3, 32'd3);
      n_wr = 1; wr_bytes[0] = 8'($urandom);
      run_stream(3, 1'b0);

      // reset mid-frame during DATA of 0x00
      wr(2'd3, 32'd4);
      wr(2'd0, 32'h0);
      repeat (12) @(negedge clk);
      check("pre_rst_tx", 32'(tx), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_tx", 32'(tx), 32'd1);
      check("async_rst_irq", 32'(IRQ), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      irq_en_m = 1'b0;
      rd_check("post_rst_status", 2'd1, 32'h4);
      rd_check("post_rst_div", 2'd3, 32'(DIV_RESET));
      rd_check("post_rst_ctrl", 2'd2, 32'd0);
      repeat (10) @(negedge clk);
      check("post_rst_idle_tx", 32'(tx), 32'd1);
      rd_check("post_rst_still_empty", 2'd1, 32'h4);

      // divisor clamp
      wr(2'd3, 32'd0);
      rd_check("clamp0", 2'd3, 32'd2);
      wr(2'd3, 32'd1);
      rd_check("clamp1", 2'd3, 32'd2);
      wr(2'd3, 32'h0003_0003);
      rd_check("div_upper_ignored", 2'd3, 32'd3);
      wr(2'd3, 32'd0);
      n_wr = 1; wr_bytes[0] = 8'($urandom);
      run_stream(2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter peripheral that hangs off the south bridge beside the LED, digital tube, button and buzzer devices. The CPU writes bytes into a small FIFO through a word-addressed register port, and the block serialises them onto a single TX pin as 8N1 frames at a programmable bit period. A level interrupt signals the south bridge when the transmitter has drained, for aggregation into HWInt.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, 2..16.
- DIV_RESET, 434: reset value of DIVISOR, in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Addr  in  [3:2]  word offset. 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = DIVISOR.
- WE  in  1  write strobe; one write per cycle it is high.
- Din  in  32  write data.
- Dout  out  32  combinational read data for the register at Addr.
- IRQ  out  1  level interrupt.
- tx  out  1  serial output; idles high.

## Operation
Register map:
- DATA (write): pushes Din[7:0] into the FIFO. Reads return 0.
- STATUS (read):
  - bit0 busy: FSM not IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - bits[8:4] FIFO count.
  - Other bits are 0.
- STATUS (write): any write clears overflow.
- CTRL: bit0 irq_en; other bits read 0.
- DIVISOR: bits[15:0]. A written value below 2 is stored as 2.

FIFO:
- Circular buffer with log2(DEPTH)+1-bit read and write pointers.
- Full when the pointers differ only in the MSB; empty when they are equal.
- A push while full (and no pop in the same cycle) is dropped and sets overflow.
- A push and pop in the same cycle are both performed, so count is unchanged. This applies when full as well: the push is accepted and overflow is not set.

Transmit FSM (IDLE, START, DATA, STOP):
- IDLE: if the FIFO is not empty, pop the head into the shift register and go to START. tx = 1.
- START: tx = 0 for one bit period, then go to DATA with bit index 0.
- DATA: tx = shift[0], LSB first. At each bit-period end, shift right and increment the index. After bit 7, go to STOP.
- STOP: tx = 1 for one bit period. At its end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx is registered from state and shift[0]; there is no glitching combinational path.

Baud counter:
- Loaded with DIVISOR-1 on entry to every bit and counts down.
- Bit-period end is the cycle the counter reads 0.
- A DIVISOR write mid-frame takes effect at the next bit load; the current bit is not stretched or cut.

IRQ:
- IRQ = irq_en & empty & (state == IDLE), registered.
- Stays asserted until software disables it or pushes data.

## Timing
- Reset values:
  - tx = 1, IRQ = 0, FSM = IDLE.
  - FIFO empty, pointers 0.
  - overflow = 0, irq_en = 0, DIVISOR = DIV_RESET.
  - Dout reflects STATUS = 0x4 when Addr = 1.
- Push latency: a WE to DATA sampled at edge E makes count and empty update after E.
- With FIFO empty and FSM in IDLE before E:
  - the pop happens at E+1;
  - tx falls after E+1;
  - busy = 1 after E+1.
- Frame length is exactly 10 × DIVISOR cycles from tx falling to the end of the stop bit.
- Back-to-back frames have the next start bit beginning on the cycle immediately after the stop bit.
- IRQ follows its condition with one cycle of register delay.
- Reset mid-frame forces tx high immediately (asynchronously) and discards the FIFO contents and the partial frame.
- Dout is purely combinational from Addr and the current registers. Reading has no side effects.

## Test plan
- Reset: pulse rst_n low mid-simulation. Required: tx = 1 and IRQ = 0 immediately; STATUS reads 0x4; DIVISOR reads DIV_RESET.
- Single byte: DIVISOR = 4, write DATA = 0xA5. Required: tx low starting 2 edges after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then a 4-cycle stop; 40 cycles total; busy clears afterwards.
- Overflow: DIVISOR = 100, write 10 bytes back-to-back. Required: the first byte is popped so 9 are accepted (1 in flight + 8 queued); the tenth sets overflow; STATUS shows full = 1 and count 8; a STATUS write clears bit3.
- Back-to-back: DIVISOR = 2, write 0x00 then 0xFF. Required: no idle cycle between the stop bit of 0x00 and the start bit of 0xFF; 40 cycles total.
- IRQ: set irq_en with FIFO empty. Required: IRQ = 1 one cycle later. Push a byte. Required: IRQ drops within 1 cycle and rises one cycle after the final stop bit ends.
- Reset mid-frame and divisor clamp: assert rst_n during the DATA phase. Required: tx = 1 immediately; FIFO empty after release. Then write DIVISOR = 0. Required: it reads back 2.
